// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO.
// Each byte goes out as an 11-bit frame: start, 8 data bits LSB first, even parity, stop.
module uart_tx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 10,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ready,
   input  logic [7:0] msg,
   output logic       tx_serial,
   output logic       busy,
   output logic       full,
   output logic       empty,
   output logic       tx_done,
   output logic       overflow
);

   localparam int unsigned PW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = PW + 1;
   localparam int unsigned BW   = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]   BIT_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CNTW-1:0] CNT_DEPTH = CNTW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state, state_n;
   logic [BW-1:0]   bit_cnt, bit_cnt_n;
   logic [2:0]      idx, idx_n;
   logic [7:0]      sh, sh_n;
   logic            par, par_n;
   logic            tx_n, done_n;
   logic            pop;
   logic            ready_q;
   logic            push_req, push_ok;
   logic [PW-1:0]   wptr, rptr;
   logic [CNTW-1:0] count, count_n;
   logic [7:0]      mem [FIFO_DEPTH];
   logic            bit_last;

   assign push_req = ready & ~ready_q;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands then.
   assign push_ok  = push_req & (~full | pop);
   assign bit_last = (bit_cnt == BIT_LAST);

   // FIFO occupancy after this edge
   always_comb begin
      count_n = count;
      case ({push_ok, pop})
         2'b10:   count_n = count + CNTW'(1);
         2'b01:   count_n = count - CNTW'(1);
         default: count_n = count;
      endcase
   end

   // Frame sequencer: next state, counters, pop and next line value
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      idx_n     = idx;
      sh_n      = sh;
      par_n     = par;
      pop       = 1'b0;
      tx_n      = 1'b1;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               sh_n      = mem[rptr];
               par_n     = ^mem[rptr];
               state_n   = START;
               bit_cnt_n = '0;
               idx_n     = '0;
            end
         end
         START: begin
            if (bit_last) begin
               state_n   = DATA;
               bit_cnt_n = '0;
               idx_n     = '0;
            end else begin
               bit_cnt_n = BW'(bit_cnt + 1'b1);
            end
         end
         DATA: begin
            if (bit_last) begin
               bit_cnt_n = '0;
               if (idx == 3'd7) state_n = PARITY;
               else             idx_n   = idx + 3'd1;
            end else begin
               bit_cnt_n = BW'(bit_cnt + 1'b1);
            end
         end
         PARITY: begin
            if (bit_last) begin
               state_n   = STOP;
               bit_cnt_n = '0;
            end else begin
               bit_cnt_n = BW'(bit_cnt + 1'b1);
            end
         end
         STOP: begin
            if (bit_last) begin
               bit_cnt_n = '0;
               idx_n     = '0;
               // Chain straight into the next frame when more data is queued.
               if (!empty) begin
                  pop     = 1'b1;
                  sh_n    = mem[rptr];
                  par_n   = ^mem[rptr];
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               bit_cnt_n = BW'(bit_cnt + 1'b1);
            end
         end
         default: state_n = IDLE;
      endcase

      // The line register is loaded with the bit belonging to the upcoming cycle.
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = sh_n[idx_n];
         PARITY:  tx_n = par_n;
         default: tx_n = 1'b1;
      endcase
      done_n = (state_n == STOP) && (bit_cnt_n == BIT_LAST);
   end

   // FSM, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         idx       <= '0;
         sh        <= '0;
         par       <= 1'b0;
         tx_serial <= 1'b1;
         tx_done   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         idx       <= idx_n;
         sh        <= sh_n;
         par       <= par_n;
         tx_serial <= tx_n;
         tx_done   <= done_n;
         busy      <= (state_n != IDLE);
      end
   end

   // FIFO pointers, occupancy flags, edge history and sticky overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q  <= 1'b0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         ready_q <= ready;
         if (push_ok) wptr <= wptr + PW'(1);
         if (pop)     rptr <= rptr + PW'(1);
         count <= count_n;
         full  <= (count_n == CNT_DEPTH);
         empty <= (count_n == '0);
         if (push_req && !push_ok) overflow <= 1'b1;
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= msg;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
UART transmit end of the wireless guess link. It is the partner of the UART receiver and buffer that produce guess, err_LED and blue.
- A rising edge on ready captures one 8-bit msg byte into a small FIFO.
- Each byte is serialised as an 11-bit frame: start, 8 data bits LSB-first, even parity, stop.
- The receiver checks this same frame format.

Parameters:
CLKS_PER_BIT, 10, clock cycles per serial bit; legal range 2 or more.
FIFO_DEPTH, 4, number of queued bytes; power of two, 2 or more.

Ports:
clk  input  1  system clock; all flops on its rising edge.
rst  input  1  asynchronous, active-high reset.
ready  input  1  load request; level input, only its rising edge is acted on.
msg  input  8  byte to send; sampled on the clock edge where the ready rising edge is detected.
tx_serial  output  1  serial line; idles high.
busy  output  1  high while a frame is on the line (any state except IDLE).
full  output  1  FIFO holds FIFO_DEPTH bytes.
empty  output  1  FIFO holds 0 bytes.
tx_done  output  1  one-cycle pulse at the end of each stop bit.
overflow  output  1  sticky flag: a load request arrived while full; cleared only by rst.

Behaviour:
- Reset (asynchronous, immediate): tx_serial=1, busy=0, full=0, empty=1, tx_done=0, overflow=0.
  - FIFO pointers, count and ready history register (ready_q) clear to 0.
  - FSM goes to IDLE.
  - Reset mid-frame aborts the frame; the line returns high at once.
- Edge detect: ready_q registers ready every cycle; push_req = ready & ~ready_q.
  - Holding ready high for any length gives exactly one push.
  - ready already high when reset deasserts counts as a rising edge on the first cycle.
- Push: on an edge with push_req=1 and full=0, msg is written and the count increments.
  - Push while full: byte dropped, overflow set to 1, FIFO unchanged.
  - Exception: a pop on the same edge frees a slot, so the push succeeds and overflow is not set.
- FSM states: IDLE, START, DATA, PARITY, STOP. A bit counter (0..CLKS_PER_BIT-1) times each bit; a 3-bit index selects the data bit.
  - IDLE: tx_serial=1. If empty=0 on an edge: pop the head into shift register sh, compute par = XOR of its 8 bits, go to START, zero counters.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_serial=sh[index], index 0 to 7, each held CLKS_PER_BIT cycles. After index 7, go to PARITY.
  - PARITY: tx_serial=par, so the total count of ones over the 8 data bits plus parity is even. Held CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles. On the last cycle tx_done=1.
    - If empty=0, pop the next byte and go straight to START, with no idle gap between frames.
    - Otherwise go to IDLE.
- tx_serial comes from a register.
- Latency: a push at edge E0 into an empty, idle block gives a pop at E1, and tx_serial is low from E1.
  - Frame length is exactly 11*CLKS_PER_BIT cycles.
- Simultaneous push and pop: count is unchanged, both pointers advance, and pointers wrap modulo FIFO_DEPTH.
- msg changing after its push edge has no effect on queued or in-flight data.

Test Plan:
- Reset then idle: rst pulse, no ready edge for 200 cycles -> tx_serial=1, busy=0, empty=1, overflow=0 throughout.
- Single byte: msg=0xA9, ready held high for 500 cycles -> exactly one frame 0,1,0,0,1,0,1,0,1,0,1, each bit 10 cycles, tx_serial low starting 1 cycle after the push edge, one tx_done pulse, then idle.
- Odd parity value: msg=0x07 -> data bits 1,1,1,0,0,0,0,0 and parity bit 1.
- Back-to-back: push 0xA9 then 0xAA, 2 cycles apart -> two frames with no high gap between the stop bit and the second start bit; second frame data 0,1,0,1,0,1,0,1, parity 0.
- Overflow: 6 pushes 2 cycles apart during the first frame -> after the 5th push full=1; the 6th push sets overflow=1 and is dropped; exactly 5 frames go out, in order.
- Reset mid-frame: assert rst during DATA bit 3 -> tx_serial=1 in the same cycle, FIFO empty, no further frames; a new push after deassert sends a complete frame.
